// File: rtl/pc_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_stage_if
// Description : Signal bundle between the fetch stage and its surroundings
//               (PC+4 adder, instruction memory, control/hazard units and
//               the decode stage). The optional misalign_trap wire exists
//               only when PC_MISALIGN_TRAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_stage_if;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr_in;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        stall;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_count;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  // Fetch-stage side: owns the PC and the IF/ID register
  modport master (
    input  pc_plus4, instr_in, branch_taken, branch_target,
           jump, jump_index, stall,
`ifdef PC_MISALIGN_TRAP_EN
    output misalign_trap,
`endif
    output pc, if_id_instr, if_id_pc4, if_id_valid, fetch_count
  );

  // Environment side: adders, memory, control and decode
  modport slave (
    output pc_plus4, instr_in, branch_taken, branch_target,
           jump, jump_index, stall,
`ifdef PC_MISALIGN_TRAP_EN
    input  misalign_trap,
`endif
    input  pc, if_id_instr, if_id_pc4, if_id_valid, fetch_count
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_stage
// Description : MIPS instruction-fetch stage: PC register, next-PC select
//               (stall > jump > branch > sequential) and IF/ID register.
//               Optional macro PC_MISALIGN_TRAP_EN: a branch to a misaligned
//               target goes to TRAP_VECTOR and pulses misalign_trap.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0000
`ifdef PC_MISALIGN_TRAP_EN
  ,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
`endif
) (
  input  logic             clk,
  input  logic             rst,
  pc_fetch_stage_if.master fetch_if
);

  typedef enum logic [0:0] {
    RESET_HOLD = 1'b0,
    RUN        = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
`ifdef PC_MISALIGN_TRAP_EN
  logic        trap_q, trap_d;
`endif

  logic [31:0] jump_target;

  // Jump target is built from the jump's own PC+4, held in IF/ID
  assign jump_target = {pc4_q[31:28], fetch_if.jump_index, 2'b00};

  // Next-state and next-PC selection; every register holds unless told otherwise
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
`ifdef PC_MISALIGN_TRAP_EN
    trap_d  = 1'b0;
`endif
    case (state_q)
      RESET_HOLD: begin
        // One idle edge after reset release; control inputs are not yet meaningful
        state_d = RUN;
      end
      RUN: begin
        if (fetch_if.stall) begin
          // Everything freezes; control unit re-presents redirects afterwards
        end else if (fetch_if.jump || fetch_if.branch_taken) begin
          if (fetch_if.jump) begin
            pc_d = jump_target;
          end else begin
            pc_d = fetch_if.branch_target;
`ifdef PC_MISALIGN_TRAP_EN
            if (fetch_if.branch_target[1:0] != 2'b00) begin
              pc_d   = TRAP_VECTOR;
              trap_d = 1'b1;
            end
`endif
          end
          // Squash the wrong-path instruction fetched this cycle
          instr_d = NOP_INSTR;
          pc4_d   = 32'h0000_0000;
          valid_d = 1'b0;
        end else begin
          pc_d    = fetch_if.pc_plus4;
          instr_d = fetch_if.instr_in;
          pc4_d   = fetch_if.pc_plus4;
          valid_d = 1'b1;
          count_d = count_q + 32'd1;
        end
      end
      default: state_d = RESET_HOLD;
    endcase
  end

  // State, PC and IF/ID registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_HOLD;
      pc_q    <= RESET_VECTOR;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
      count_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // One-cycle trap pulse following a misaligned branch redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign fetch_if.misalign_trap = trap_q;
`endif

  assign fetch_if.pc          = pc_q;
  assign fetch_if.if_id_instr = instr_q;
  assign fetch_if.if_id_pc4   = pc4_q;
  assign fetch_if.if_id_valid = valid_q;
  assign fetch_if.fetch_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_stage
// Description : Self-checking bench for pc_fetch_stage: directed scenarios
//               followed by randomized control traffic against a reference
//               model of the fetch rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_stage;

  localparam logic [31:0] C_NOP  = 32'h0000_0000;
  localparam logic [31:0] C_TRAP = 32'h0000_0080;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit C_TRAP_EN = 1'b1;
`else
  localparam bit C_TRAP_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  pc_fetch_stage_if bus ();

  pc_fetch_stage dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_if (bus)
  );

  // Environment: PC+4 adder and a combinational instruction ROM
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h8C3A, a[31:16] ^ 16'h1F07} + 32'h0123_4567;
  endfunction

  assign bus.pc_plus4 = bus.pc + 32'd4;
  assign bus.instr_in = mem_word(bus.pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the architectural state
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_trap;
  bit          m_hold;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = C_NOP; m_pc4 = 32'h0; m_count = 32'h0;
    m_valid = 1'b0; m_trap = 1'b0; m_hold = 1'b1;
  endtask

  // Drive controls at the falling edge, advance model at the rising edge,
  // and return at the next falling edge ready for sampling
  task automatic cycle(input logic st, input logic br, input logic jp,
                       input logic [31:0] bt, input logic [25:0] ji);
    logic [31:0] tgt;
    bus.stall = st; bus.branch_taken = br; bus.jump = jp;
    bus.branch_target = bt; bus.jump_index = ji;
    @(posedge clk);
    m_trap = 1'b0;
    if (m_hold) begin
      m_hold = 1'b0;
    end else if (st) begin
      // frozen
    end else if (jp || br) begin
      tgt = jp ? {m_pc4[31:28], ji, 2'b00} : bt;
      if (!jp && C_TRAP_EN && bt[1:0] != 2'b00) begin
        tgt = C_TRAP; m_trap = 1'b1;
      end
      m_pc = tgt; m_instr = C_NOP; m_pc4 = 32'h0; m_valid = 1'b0;
    end else begin
      m_instr = mem_word(m_pc); m_pc = m_pc + 32'd4; m_pc4 = m_pc;
      m_valid = 1'b1; m_count = m_count + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.jump = 1'b0;
    bus.branch_target = 32'h0; bus.jump_index = 26'h0;
    repeat (3) @(negedge clk);
    model_reset();
    n_vec++;
    if (bus.pc !== 32'h0 || bus.if_id_valid !== 1'b0 || bus.fetch_count !== 32'h0 ||
        bus.if_id_instr !== C_NOP || bus.if_id_pc4 !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: pc=%h valid=%b cnt=%h instr=%h pc4=%h, want all zero/NOP",
               bus.pc, bus.if_id_valid, bus.fetch_count, bus.if_id_instr, bus.if_id_pc4);
    end
    rst = 1'b0;
  endtask

  task automatic test_run();
    cycle(0, 0, 0, 32'h0, 26'h0);
    n_vec++;
    if (bus.pc !== 32'h0 || bus.if_id_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_hold: pc=%h valid=%b, want 0/0", bus.pc, bus.if_id_valid);
    end
    cycle(0, 0, 0, 32'h0, 26'h0);
    n_vec++;
    if (bus.pc !== 32'h4 || bus.if_id_valid !== 1'b1 || bus.if_id_pc4 !== 32'h4 ||
        bus.fetch_count !== 32'd1 || bus.if_id_instr !== mem_word(32'h0)) begin
      n_err++;
      $display("FAIL first_fetch: pc=%h valid=%b pc4=%h cnt=%0d instr=%h, want 4/1/4/1/%h",
               bus.pc, bus.if_id_valid, bus.if_id_pc4, bus.fetch_count, bus.if_id_instr,
               mem_word(32'h0));
    end
    cycle(0, 0, 0, 32'h0, 26'h0);
    n_vec++;
    if (bus.pc !== 32'h8 || bus.if_id_pc4 !== 32'h8 || bus.fetch_count !== 32'd2) begin
      n_err++;
      $display("FAIL second_fetch: pc=%h pc4=%h cnt=%0d, want 8/8/2",
               bus.pc, bus.if_id_pc4, bus.fetch_count);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 0, 32'h0, 26'h0);
      n_vec++;
      if (bus.pc !== 32'h8 || bus.if_id_pc4 !== 32'h8 || bus.fetch_count !== 32'd2 ||
          bus.if_id_instr !== mem_word(32'h4)) begin
        n_err++;
        $display("FAIL stall_hold: pc=%h pc4=%h cnt=%0d instr=%h, want 8/8/2/%h",
                 bus.pc, bus.if_id_pc4, bus.fetch_count, bus.if_id_instr, mem_word(32'h4));
      end
    end
    cycle(0, 0, 0, 32'h0, 26'h0);
    n_vec++;
    if (bus.pc !== 32'hC || bus.fetch_count !== 32'd3) begin
      n_err++; $display("FAIL stall_release: pc=%h cnt=%0d, want c/3", bus.pc, bus.fetch_count);
    end
  endtask

  task automatic test_branch();
    cycle(0, 1, 0, 32'h40, 26'h0);
    n_vec++;
    if (bus.pc !== 32'h40 || bus.if_id_valid !== 1'b0 || bus.if_id_instr !== C_NOP ||
        bus.if_id_pc4 !== 32'h0 || bus.fetch_count !== 32'd3) begin
      n_err++;
      $display("FAIL branch_flush: pc=%h valid=%b instr=%h pc4=%h cnt=%0d, want 40/0/NOP/0/3",
               bus.pc, bus.if_id_valid, bus.if_id_instr, bus.if_id_pc4, bus.fetch_count);
    end
    cycle(0, 0, 0, 32'h0, 26'h0);
    n_vec++;
    if (bus.pc !== 32'h44 || bus.if_id_valid !== 1'b1 || bus.if_id_pc4 !== 32'h44) begin
      n_err++;
      $display("FAIL branch_resume: pc=%h valid=%b pc4=%h, want 44/1/44",
               bus.pc, bus.if_id_valid, bus.if_id_pc4);
    end
  endtask

  task automatic test_jump_priority();
    cycle(0, 1, 0, 32'h1000_0004, 26'h0);
    cycle(0, 0, 0, 32'h0, 26'h0);
    n_vec++;
    if (bus.if_id_pc4 !== 32'h1000_0008) begin
      n_err++; $display("FAIL jump_setup: pc4=%h, want 10000008", bus.if_id_pc4);
    end
    cycle(0, 1, 1, 32'h80, 26'h000_0010);
    n_vec++;
    if (bus.pc !== 32'h1000_0040 || bus.if_id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL jump_priority: pc=%h valid=%b, want 10000040/0", bus.pc, bus.if_id_valid);
    end
  endtask

  task automatic test_stall_beats_redirect();
    cycle(0, 1, 0, 32'h1C, 26'h0);
    cycle(0, 0, 0, 32'h0, 26'h0);
    cycle(1, 1, 0, 32'h40, 26'h0);
    n_vec++;
    if (bus.pc !== 32'h20 || bus.if_id_valid !== 1'b1 || bus.if_id_pc4 !== 32'h20) begin
      n_err++;
      $display("FAIL stall_over_branch: pc=%h valid=%b pc4=%h, want 20/1/20",
               bus.pc, bus.if_id_valid, bus.if_id_pc4);
    end
  endtask

  task automatic test_async_reset();
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.jump = 1'b0;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.pc !== 32'h0 || bus.fetch_count !== 32'h0 || bus.if_id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: pc=%h cnt=%h valid=%b, want 0/0/0",
               bus.pc, bus.fetch_count, bus.if_id_valid);
    end
    #1 rst = 1'b0;
    model_reset();
    cycle(0, 1, 0, 32'h40, 26'h0);
    n_vec++;
    if (bus.pc !== 32'h0 || bus.if_id_valid !== 1'b0) begin
      n_err++; $display("FAIL hold_after_async: pc=%h valid=%b, want 0/0", bus.pc, bus.if_id_valid);
    end
    cycle(0, 0, 0, 32'h0, 26'h0);
    n_vec++;
    if (bus.pc !== 32'h4 || bus.fetch_count !== 32'd1) begin
      n_err++; $display("FAIL run_after_async: pc=%h cnt=%0d, want 4/1", bus.pc, bus.fetch_count);
    end
  endtask

  task automatic test_misalign();
    cycle(0, 1, 0, 32'h42, 26'h0);
`ifdef PC_MISALIGN_TRAP_EN
    n_vec++;
    if (bus.pc !== C_TRAP || bus.misalign_trap !== 1'b1 || bus.if_id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL misalign_trap: pc=%h trap=%b valid=%b, want 80/1/0",
               bus.pc, bus.misalign_trap, bus.if_id_valid);
    end
    cycle(0, 0, 0, 32'h0, 26'h0);
    n_vec++;
    if (bus.pc !== 32'h84 || bus.misalign_trap !== 1'b0) begin
      n_err++;
      $display("FAIL trap_pulse: pc=%h trap=%b, want 84/0", bus.pc, bus.misalign_trap);
    end
`else
    n_vec++;
    if (bus.pc !== 32'h42 || bus.if_id_valid !== 1'b0) begin
      n_err++; $display("FAIL misalign_load: pc=%h valid=%b, want 42/0", bus.pc, bus.if_id_valid);
    end
    cycle(0, 0, 0, 32'h0, 26'h0);
    n_vec++;
    if (bus.pc !== 32'h46 || bus.if_id_pc4 !== 32'h46) begin
      n_err++; $display("FAIL misalign_seq: pc=%h pc4=%h, want 46/46", bus.pc, bus.if_id_pc4);
    end
`endif
  endtask

  task automatic test_random();
    logic        st, br, jp;
    logic [31:0] bt;
    logic [25:0] ji;
    int          errs_here;
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 99) < 20);
      br = ($urandom_range(0, 99) < 15);
      jp = ($urandom_range(0, 99) < 10);
      bt = $urandom;
      if ($urandom_range(0, 9) != 0) bt[1:0] = 2'b00;
      ji = 26'($urandom);
      cycle(st, br, jp, bt, ji);
      errs_here = 0;
      n_vec++;
      if (bus.pc !== m_pc || bus.if_id_instr !== m_instr || bus.if_id_pc4 !== m_pc4 ||
          bus.if_id_valid !== m_valid || bus.fetch_count !== m_count) begin
        n_err++; errs_here++;
        $display("FAIL random[%0d]: pc=%h instr=%h pc4=%h v=%b cnt=%h, want %h %h %h %b %h",
                 i, bus.pc, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid, bus.fetch_count,
                 m_pc, m_instr, m_pc4, m_valid, m_count);
      end
`ifdef PC_MISALIGN_TRAP_EN
      n_vec++;
      if (bus.misalign_trap !== m_trap) begin
        n_err++; errs_here++;
        $display("FAIL random_trap[%0d]: trap=%b, want %b", i, bus.misalign_trap, m_trap);
      end
`endif
      if (errs_here != 0) break;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_run();
    test_stall();
    test_branch();
    test_jump_priority();
    test_stall_beats_redirect();
    test_async_reset();
    test_misalign();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
